imem_loader: RTL and testbench

Boot-time program loader that writes instruction memory for the single-cycle riscv core. It accepts a byte stream over a valid/ready handshake, parses a 16-bit little-endian word-count header, and packs each group of four bytes little-endian into a 32-bit instruction word. It writes each word to consecutive instruction-memory addresses starting at 0, and holds the core in reset until the image is fully written. It is the writer side of the instruction-memory read port that the core fetches from.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 110 +++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: loader FSM states and stream framing constants.
// Optional trailing-checksum stage is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } ldr_state_e;

  localparam int LDR_HDR_BYTES  = 2;
  localparam int LDR_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects stream bytes little-endian into a 32-bit word.
// o_full flags that the next load completes the word.
import imem_loader_pkg::*;

module byte_packer (
  input  logic        clk,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_full
);

  localparam int CW = $clog2(LDR_WORD_BYTES);

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_word;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_load) begin
      r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_word = r_word;
  assign o_full = (r_cnt == CW'(LDR_WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a counted image into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ldr_state_e END_ST = CSUM;
`else
  localparam ldr_state_e END_ST = DONE;
`endif

  ldr_state_e        r_state;
  logic [15:0]       r_count;
  logic [ADDR_W-1:0] r_idx;

  logic        w_acc;
  logic [15:0] w_cnt;
  logic [15:0] w_idx_nxt;
  logic        w_full;
  logic [31:0] w_word;

  assign w_acc     = in_valid & in_ready;
  assign w_cnt     = {in_data, r_count[7:0]};
  assign w_idx_nxt = 16'(r_idx) + 16'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst)
      r_csum <= '0;
    else if (w_acc && r_state != CSUM)
      r_csum <= r_csum ^ in_data;
  end
`endif

  byte_packer u_pack (
    .clk    (clk),
    .i_clr  (rst),
    .i_load (w_acc && r_state == DATA),
    .i_byte (in_data),
    .o_word (w_word),
    .o_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HDR0;
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        HDR0: if (w_acc) begin
          r_count[7:0] <= in_data;
          r_state      <= HDR1;
        end
        HDR1: if (w_acc) begin
          r_count <= w_cnt;
          if (w_cnt == 16'd0)
            r_state <= END_ST;
          else if ({1'b0, w_cnt} > DEPTH)
            r_state <= ERR;
          else
            r_state <= DATA;
        end
        DATA: if (w_acc && w_full)
          r_state <= WRITE;
        WRITE: begin
          r_idx   <= r_idx + 1'b1;
          r_state <= (w_idx_nxt == r_count) ? END_ST : DATA;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (w_acc)
          r_state <= (in_data == r_csum) ? DONE : ERR;
`endif
        DONE: r_state <= DONE;
        ERR:  r_state <= ERR;
        default: r_state <= ERR;
      endcase
    end
  end

  // All outputs decode from the state register; mem_wd is the packer register.
  assign in_ready = (r_state == HDR0) || (r_state == HDR1) ||
                    (r_state == DATA) || (r_state == CSUM);
  assign mem_we   = (r_state == WRITE);
  assign mem_addr = r_idx;
  assign mem_wd   = w_word;
  assign done     = (r_state == DONE);
  assign err      = (r_state == ERR);
  assign cpu_rst  = (r_state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Also builds with IMEM_LOADER_CHECKSUM_EN to exercise the trailing byte.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic          cpu_rst;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            nwr = 0;
  int            b2b = 0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] wa [0:63];
  logic [31:0]   wd [0:63];

  always @(posedge clk) begin
    if (mem_we) begin
      if (nwr < 64) begin
        wa[nwr] <= mem_addr;
        wd[nwr] <= mem_wd;
      end
      nwr <= nwr + 1;
    end
    if (mem_we && prev_we) b2b <= b2b + 1;
    prev_we <= mem_we;
  end

  logic [7:0]  S  [0:13] = '{8'h03, 8'h00,
                             8'h13, 8'hc0, 8'h52, 8'h01,
                             8'h13, 8'hc2, 8'h52, 8'h01,
                             8'h13, 8'h42, 8'h52, 8'h01};
  logic [31:0] EW [0:2]  = '{32'h0152c013, 32'h0152c213, 32'h01524213};
  logic [7:0]  csum;

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    csum     = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b want 1", b, in_ready);
    end
    csum = csum ^ b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    if (mem_we !== 1'b0)   begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    if (mem_addr !== '0)   begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    if (mem_wd !== 32'h0)  begin errors++; $display("FAIL rst_mem_wd got %h want 0", mem_wd); end
    if (cpu_rst !== 1'b1)  begin errors++; $display("FAIL rst_cpu_rst got %b want 1", cpu_rst); end
    if (done !== 1'b0)     begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (err !== 1'b0)      begin errors++; $display("FAIL rst_err got %b want 0", err); end
  endtask

  task automatic test_stream(input int gapmax, input string name);
    int base;
    do_reset();
    base = nwr;
    for (int i = 0; i < 14; i++)
      send(S[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
    checks++;
    if (mem_we !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_last_write we=%b done=%b want 1 0", name, mem_we, done);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(csum, 0);
`else
    @(negedge clk);
`endif
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s_done done=%b cpu_rst=%b err=%b want 1 0 0",
               name, done, cpu_rst, err);
    end
    checks++;
    if (nwr - base !== 3) begin
      errors++;
      $display("FAIL %s_nwrites got %0d want 3", name, nwr - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wa[base+i] !== AW'(i) || wd[base+i] !== EW[i]) begin
        errors++;
        $display("FAIL %s_word%0d got %h@%h want %h@%h",
                 name, i, wd[base+i], wa[base+i], EW[i], AW'(i));
      end
    end
    checks++;
    if (b2b !== 0) begin
      errors++;
      $display("FAIL %s_b2b_we got %0d want 0", name, b2b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_hold done=%b in_ready=%b want 1 0", name, done, in_ready);
    end
  endtask

  task automatic test_zero();
    int base;
    do_reset();
    base = nwr;
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_csum_wait done=%b in_ready=%b want 0 1", done, in_ready);
    end
    send(8'h00, 0);
`endif
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL zero_done done=%b cpu_rst=%b want 1 0", done, cpu_rst);
    end
    checks++;
    if (nwr - base !== 0) begin
      errors++;
      $display("FAIL zero_nwrites got %0d want 0", nwr - base);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    base = nwr;
    send(8'h01, 0);
    send(8'h01, 0);
    in_valid = 1'b1;
    in_data  = 8'h13;
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state err=%b cpu_rst=%b done=%b in_ready=%b want 1 1 0 0",
               err, cpu_rst, done, in_ready);
    end
    checks++;
    if (nwr - base !== 0) begin
      errors++;
      $display("FAIL ovf_nwrites got %0d want 0", nwr - base);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    base = nwr;
    for (int i = 0; i < 8; i++) send(S[i], 0);
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_state rdy=%b we=%b cpu_rst=%b done=%b want 1 0 1 0",
               in_ready, mem_we, cpu_rst, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (nwr - base !== 1 || wd[base] !== EW[0]) begin
      errors++;
      $display("FAIL mid_partial nwr=%0d wd=%h want 1 %h", nwr - base, wd[base], EW[0]);
    end
    test_stream(0, "reload");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    do_reset();
    for (int i = 0; i < 14; i++) send(S[i], 0);
    @(negedge clk);
    send(csum ^ 8'h01, 0);
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum err=%b cpu_rst=%b done=%b want 1 1 0", err, cpu_rst, done);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    csum     = 8'h00;
    test_reset();
    test_stream(0, "basic");
    test_zero();
    test_overflow();
    test_stream(3, "gaps");
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
